cp0_gen: RTL

- Parametrised second-generation MIPS coprocessor 0 for the 5-stage pipeline.
- Holds SR, Cause, EPC, PrID and BadVAddr, and accepts interrupts and exceptions from the M stage.
- Generalises hardware interrupt count; adds BD/TI Cause bits, BadVAddr capture, defined event priority and an optional Count/Compare timer.
- Its outputs drive the pipeline flush and handler-PC redirect logic.

---
 rtl/cp0_gen_pkg.sv | 36 +++
 rtl/cp0_timer.sv | 64 ++++++
 rtl/cp0_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cp0_gen_pkg.sv
// cp0_gen_pkg: register numbers, SR/Cause field positions, ExcCode values
// and the EPC helper shared by the coprocessor 0 files.
package cp0_gen_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Return address for the handler: a delay-slot instruction restarts at
  // its branch, one word back (word index wraps modulo 2^30).
  function automatic logic [31:0] epc_calc(input logic [31:0] pc, input logic bd);
    logic [29:0] w;
    w = bd ? (pc[31:2] - 30'd1) : pc[31:2];
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: prescaler plus Count/Compare with a sticky TI flag.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wr_data,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d, compare_q, compare_d, count_inc;
  logic          ti_q, ti_d, presc_wrap;

  // Next-state: a Count write restarts the prescaler; a Compare write clears TI.
  always_comb begin
    presc_d    = presc_q;
    count_d    = count_q;
    compare_d  = compare_q;
    ti_d       = ti_q;
    presc_wrap = (presc_q == PW'(COUNT_DIV - 1));
    count_inc  = count_q + 32'd1;
    if (count_we) begin
      count_d = wr_data;
      presc_d = '0;
    end else begin
      presc_d = presc_wrap ? '0 : presc_q + PW'(1);
      if (presc_wrap) begin
        count_d = count_inc;
        if (count_inc == compare_q) ti_d = 1'b1;
      end
    end
    if (compare_we) begin
      compare_d = wr_data;
      ti_d      = 1'b0;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_gen.sv
// cp0_gen: MIPS coprocessor 0 (SR, Cause, EPC, PrID, BadVAddr) with
// interrupt/exception acceptance for the M stage.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_gen
  import cp0_gen_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h0000_C0DE,
  parameter int          COUNT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 we,
  input  logic [31:0]          pc,
  input  logic                 in_bd,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          bad_vaddr,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 eret,
  output logic                 int_req,
  output logic                 exc_take,
  output logic [31:0]          epc_out,
  output logic [31:0]          rd_data
);

  logic [NUM_HWINT-1:0] sr_im_q, sr_im_d, cause_ip_q, cause_ip_d;
  logic                 sr_exl_q, sr_exl_d, sr_ie_q, sr_ie_d;
  logic                 cause_bd_q, cause_bd_d;
  logic [4:0]           cause_exc_q, cause_exc_d;
  logic [31:0]          epc_q, epc_d, badva_q, badva_d;
  logic [NUM_HWINT-1:0] ip_eff, ip_rd;
  logic                 exc_req, wr_ok, ti;
  logic [31:0]          sr_rd, cause_rd;
  logic [1:0]           unused_pc;

  assign unused_pc = pc[1:0];

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_ok && (wr_addr == REG_COUNT)),
    .compare_we (wr_ok && (wr_addr == REG_COMPARE)),
    .wr_data    (wr_data),
    .count_o    (count),
    .compare_o  (compare),
    .ti_o       (ti)
  );
`else
  localparam int UNUSED_DIV = COUNT_DIV;
  assign ti = 1'b0;
`endif

  // Acceptance logic; TI shares the top hardware interrupt line.
  always_comb begin
    ip_eff = hw_int;
    ip_rd  = cause_ip_q;
    ip_eff[NUM_HWINT-1] = hw_int[NUM_HWINT-1] | ti;
    ip_rd[NUM_HWINT-1]  = cause_ip_q[NUM_HWINT-1] | ti;
    int_req  = (|(ip_eff & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_req  = (exc_code != EXC_INT) & ~sr_exl_q;
    exc_take = int_req | exc_req;
    wr_ok    = we & ~exc_take;
  end

  // Next-state: accept beats eret beats mtc0; eret's EXL clear beats an SR write.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    cause_ip_d  = hw_int;
    epc_d       = epc_q;
    badva_d     = badva_q;
    if (exc_take) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_req ? EXC_INT : exc_code;
      cause_bd_d  = in_bd;
      epc_d       = epc_calc(pc, in_bd);
      if (!int_req && (exc_code == EXC_ADEL || exc_code == EXC_ADES))
        badva_d = bad_vaddr;
    end else begin
      if (wr_ok) begin
        case (wr_addr)
          REG_SR: begin
            sr_im_d  = wr_data[SR_IM_LO +: NUM_HWINT];
            sr_exl_d = wr_data[SR_EXL];
            sr_ie_d  = wr_data[SR_IE];
          end
          REG_EPC: epc_d = {wr_data[31:2], 2'b00};
          default: ;
        endcase
      end
      if (eret) sr_exl_d = 1'b0;
    end
  end

  // Architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_exc_q <= '0;
      cause_ip_q  <= '0;
      epc_q       <= '0;
      badva_q     <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_exc_q <= cause_exc_d;
      cause_ip_q  <= cause_ip_d;
      epc_q       <= epc_d;
      badva_q     <= badva_d;
    end
  end

  // mfc0 read mux from current state.
  always_comb begin
    sr_rd    = '0;
    cause_rd = '0;
    sr_rd[SR_IM_LO +: NUM_HWINT]       = sr_im_q;
    sr_rd[SR_EXL]                      = sr_exl_q;
    sr_rd[SR_IE]                       = sr_ie_q;
    cause_rd[CAUSE_BD]                 = cause_bd_q;
    cause_rd[CAUSE_TI]                 = ti;
    cause_rd[CAUSE_IP_LO +: NUM_HWINT] = ip_rd;
    cause_rd[CAUSE_EXC_LO +: 5]        = cause_exc_q;
    case (rd_addr)
      REG_BADVADDR: rd_data = badva_q;
`ifdef CP0_TIMER_EN
      REG_COUNT:    rd_data = count;
      REG_COMPARE:  rd_data = compare;
`endif
      REG_SR:       rd_data = sr_rd;
      REG_CAUSE:    rd_data = cause_rd;
      REG_EPC:      rd_data = epc_q;
      REG_PRID:     rd_data = PRID_VAL;
      default:      rd_data = '0;
    endcase
  end

  assign epc_out = epc_q;

endmodule
